// File: rtl/isa_types.sv
// Core-wide ISA types shared between the hart and its memory-mapped peripherals.
package isa_types;

  localparam int XLEN = 32;

  typedef enum logic [1:0] {
    WIDTH_BYTE = 2'd0,
    WIDTH_HALF = 2'd1,
    WIDTH_WORD = 2'd2
  } mem_width_t;

  typedef struct packed {
    logic [XLEN-1:0] addr;
    mem_width_t      width;
    logic            enable;
    logic [XLEN-1:0] value;
  } mem_write_control_t;

endpackage

// File: rtl/mmio_pkg.sv
// Register offsets and STATUS layout for the MMIO peripheral hub window.
package mmio_pkg;

  localparam int MMIO_WINDOW_BITS = 5;

  localparam logic [MMIO_WINDOW_BITS-1:0] MMIO_TX_DATA   = 5'h00;
  localparam logic [MMIO_WINDOW_BITS-1:0] MMIO_LED_WRITE = 5'h04;
  localparam logic [MMIO_WINDOW_BITS-1:0] MMIO_LED_SET   = 5'h08;
  localparam logic [MMIO_WINDOW_BITS-1:0] MMIO_LED_CLR   = 5'h0C;
  localparam logic [MMIO_WINDOW_BITS-1:0] MMIO_STATUS    = 5'h10;

  localparam int STATUS_COUNT_LSB = 0;
  localparam int STATUS_COUNT_W   = 8;
  localparam int STATUS_EMPTY_BIT = 8;
  localparam int STATUS_FULL_BIT  = 9;
  localparam int STATUS_ERR_BIT   = 10;

endpackage

// File: rtl/mmio_tx_fifo.sv
// Byte FIFO feeding the serial transmitter; rdata always shows the oldest entry.
module mmio_tx_fifo #(
  parameter  int DEPTH = 8,
  localparam int CW    = $clog2(DEPTH + 1),
  localparam int PW    = $clog2(DEPTH)
) (
  input  logic          clock,
  input  logic          reset_n,
  input  logic          push,
  input  logic          pop,
  input  logic [7:0]    wdata,
  output logic [7:0]    rdata,
  output logic          full,
  output logic          empty,
  output logic [CW-1:0] count
);

  logic [7:0]    mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic          push_ok;
  logic          pop_ok;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;
  assign rdata   = mem[rd_ptr];

  // Storage has no reset; validity is tracked purely by count.
  always_ff @(posedge clock) begin
    if (push_ok) begin
      mem[wr_ptr] <= wdata;
    end
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop_ok) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({push_ok, pop_ok})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/mmio_peripheral_hub.sv
// MMIO window for board I/O: buffered serial TX, latched LEDs with set/clear, STATUS.
module mmio_peripheral_hub
  import isa_types::*;
  import mmio_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR  = 32'h0003_0000,
  parameter int          FIFO_DEPTH = 8,
  parameter int          NUM_LEDS   = 2
) (
  input  logic                clock,
  input  logic                reset_n,
  input  mem_write_control_t  mmio_control,
  output logic [XLEN-1:0]     mmio_r_data,
  output logic                mmio_complete,
  output logic [7:0]          tx_data,
  output logic                tx_data_available,
  input  logic                tx_ready,
  output logic [NUM_LEDS-1:0] leds
);

  localparam int CW = $clog2(FIFO_DEPTH + 1);

  logic [MMIO_WINDOW_BITS-1:0] offset;
  logic                        hit;
  logic                        tx_sel;
  logic                        tx_byte;
  logic                        fifo_push;
  logic                        fifo_pop;
  logic                        fifo_full;
  logic                        fifo_empty;
  logic [CW-1:0]               fifo_count;
  logic [NUM_LEDS-1:0]         led_value;
  logic                        err;
  logic [XLEN-1:0]             status;
  logic                        unused_value_bits;

  assign offset    = mmio_control.addr[MMIO_WINDOW_BITS-1:0];
  assign hit       = mmio_control.enable &&
                     (mmio_control.addr[XLEN-1:MMIO_WINDOW_BITS] == BASE_ADDR[XLEN-1:MMIO_WINDOW_BITS]);
  assign tx_sel    = hit && (offset == MMIO_TX_DATA);
  assign tx_byte   = (mmio_control.width == WIDTH_BYTE);
  assign led_value = mmio_control.value[NUM_LEDS-1:0];

  assign unused_value_bits = ^mmio_control.value[XLEN-1:8];

  // TX handshake: a byte transfers on a posedge where tx_data_available (valid)
  // and tx_ready are both high; tx_data stays stable until that edge.
  assign tx_data_available = reset_n && !fifo_empty;
  assign fifo_pop          = tx_data_available && tx_ready;
  assign fifo_push         = reset_n && tx_sel && tx_byte && !fifo_full;

  mmio_tx_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_tx_fifo (
    .clock   (clock),
    .reset_n (reset_n),
    .push    (fifo_push),
    .pop     (fifo_pop),
    .wdata   (mmio_control.value[7:0]),
    .rdata   (tx_data),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .count   (fifo_count)
  );

  // A byte store to a full FIFO is held off so the hart stalls instead of losing data.
  always_comb begin
    mmio_complete = 1'b0;
    if (reset_n && hit) begin
      mmio_complete = !(tx_sel && tx_byte && fifo_full);
    end
  end

  always_comb begin
    status = '0;
    status[STATUS_COUNT_LSB +: STATUS_COUNT_W] = STATUS_COUNT_W'(fifo_count);
    status[STATUS_EMPTY_BIT] = fifo_empty;
    status[STATUS_FULL_BIT]  = fifo_full;
    status[STATUS_ERR_BIT]   = err;
  end

  always_comb begin
    mmio_r_data = '0;
    if (hit && (offset == MMIO_STATUS)) begin
      mmio_r_data = status;
    end
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      leds <= '0;
      err  <= 1'b0;
    end else if (hit) begin
      case (offset)
        MMIO_LED_WRITE: leds <= led_value;
        MMIO_LED_SET:   leds <= leds | led_value;
        MMIO_LED_CLR:   leds <= leds & ~led_value;
        MMIO_STATUS:    err  <= 1'b0;
        MMIO_TX_DATA: begin
          if (!tx_byte) begin
            err <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mmio_peripheral_hub.sv
// Self-checking bench for mmio_peripheral_hub: TX ordering scoreboard, LED/decode table, stall and reset sequences.
module tb_mmio_peripheral_hub;
  import isa_types::*;
  import mmio_pkg::*;

  localparam logic [31:0] BASE  = 32'h0003_0000;
  localparam int          DEPTH = 8;
  localparam int          NLED  = 2;

  logic               clock = 1'b0;
  logic               reset_n;
  mem_write_control_t mmio_control;
  logic [31:0]        mmio_r_data;
  logic               mmio_complete;
  logic [7:0]         tx_data;
  logic               tx_data_available;
  logic               tx_ready;
  logic [NLED-1:0]    leds;

  int n_checks = 0;
  int n_fail   = 0;
  logic [7:0] exp_q[$];

  typedef struct {
    logic [31:0]     addr;
    mem_width_t      width;
    logic [31:0]     value;
    logic            exp_complete;
    logic [NLED-1:0] exp_leds;
    logic [31:0]     exp_status;
  } vec_t;

  vec_t vecs[15];

  mmio_peripheral_hub #(
    .BASE_ADDR  (BASE),
    .FIFO_DEPTH (DEPTH),
    .NUM_LEDS   (NLED)
  ) dut (
    .clock             (clock),
    .reset_n           (reset_n),
    .mmio_control      (mmio_control),
    .mmio_r_data       (mmio_r_data),
    .mmio_complete     (mmio_complete),
    .tx_data           (tx_data),
    .tx_data_available (tx_data_available),
    .tx_ready          (tx_ready),
    .leds              (leds)
  );

  // Clock / watchdog
  always #5 clock = ~clock;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [31:0] reg_addr(input logic [4:0] off);
    return BASE + {27'd0, off};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Scoreboard: every byte the transmitter takes must match the oldest accepted store.
  initial begin
    forever begin
      @(negedge clock);
      #2;
      if (tx_data_available && tx_ready) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL tx_unexpected: got byte 0x%0h with no byte expected", tx_data);
        end else begin
          check("tx_data", {24'd0, tx_data}, {24'd0, exp_q.pop_front()});
        end
      end
    end
  end

  // Drivers
  task automatic access(input logic [31:0] addr, input mem_width_t w, input logic [31:0] val,
                        input logic rdy, input int max_cycles, output logic ok, output logic [31:0] rd);
    int n;
    n = 0;
    @(negedge clock);
    tx_ready     = rdy;
    mmio_control = '{addr: addr, width: w, enable: 1'b1, value: val};
    ok = 1'b0;
    rd = '0;
    #1;
    while (1'b1) begin
      if (mmio_complete) begin
        ok = 1'b1;
        rd = mmio_r_data;
        break;
      end
      n++;
      if (n >= max_cycles) break;
      @(negedge clock);
      #1;
    end
    if (ok && addr == reg_addr(MMIO_TX_DATA) && w == WIDTH_BYTE) exp_q.push_back(val[7:0]);
    @(posedge clock);
    #1;
    mmio_control.enable = 1'b0;
  endtask

  task automatic peek(input logic [31:0] addr, output logic [31:0] rd);
    @(negedge clock);
    mmio_control = '{addr: addr, width: WIDTH_WORD, enable: 1'b1, value: 32'd0};
    #1;
    rd = mmio_r_data;
    mmio_control.enable = 1'b0;
  endtask

  task automatic drain(input string name);
    int n;
    n = 0;
    @(negedge clock);
    tx_ready = 1'b1;
    while (exp_q.size() != 0 && n < 40) begin
      @(negedge clock);
      n++;
    end
    #3;
    check({name, "_queue_left"}, exp_q.size(), 0);
    check({name, "_avail"}, {31'd0, tx_data_available}, 0);
    tx_ready = 1'b0;
  endtask

  initial begin
    logic        ok;
    logic [31:0] rd;
    logic        rdy;

    vecs[0]  = '{reg_addr(MMIO_LED_WRITE), WIDTH_WORD, 32'h1,         1'b1, 2'b01, 32'h100};
    vecs[1]  = '{reg_addr(MMIO_LED_SET),   WIDTH_WORD, 32'h2,         1'b1, 2'b11, 32'h100};
    vecs[2]  = '{reg_addr(MMIO_LED_CLR),   WIDTH_WORD, 32'h1,         1'b1, 2'b10, 32'h100};
    vecs[3]  = '{reg_addr(MMIO_LED_WRITE), WIDTH_WORD, 32'hFF,        1'b1, 2'b11, 32'h100};
    vecs[4]  = '{reg_addr(MMIO_TX_DATA),   WIDTH_WORD, 32'h55,        1'b1, 2'b11, 32'h500};
    vecs[5]  = '{reg_addr(MMIO_STATUS),    WIDTH_WORD, 32'h0,         1'b1, 2'b11, 32'h100};
    vecs[6]  = '{BASE + 32'h40,            WIDTH_WORD, 32'h0,         1'b0, 2'b11, 32'h100};
    vecs[7]  = '{BASE + 32'h44,            WIDTH_WORD, 32'h0,         1'b0, 2'b11, 32'h100};
    vecs[8]  = '{BASE + 32'h14,            WIDTH_WORD, 32'h0,         1'b1, 2'b11, 32'h100};
    vecs[9]  = '{reg_addr(MMIO_TX_DATA),   WIDTH_HALF, 32'h66,        1'b1, 2'b11, 32'h500};
    vecs[10] = '{reg_addr(MMIO_LED_CLR),   WIDTH_WORD, 32'h3,         1'b1, 2'b00, 32'h500};
    vecs[11] = '{BASE - 32'h18,            WIDTH_WORD, 32'h3,         1'b0, 2'b00, 32'h500};
    vecs[12] = '{reg_addr(MMIO_STATUS),    WIDTH_BYTE, 32'h0,         1'b1, 2'b00, 32'h100};
    vecs[13] = '{reg_addr(MMIO_LED_SET),   WIDTH_WORD, 32'h5,         1'b1, 2'b01, 32'h100};
    vecs[14] = '{reg_addr(MMIO_LED_WRITE), WIDTH_WORD, 32'hFFFF_FFFE, 1'b1, 2'b10, 32'h100};

    // Reset
    reset_n      = 1'b0;
    tx_ready     = 1'b0;
    mmio_control = '{addr: 32'd0, width: WIDTH_BYTE, enable: 1'b0, value: 32'd0};
    repeat (3) @(posedge clock);
    @(negedge clock);
    mmio_control = '{addr: reg_addr(MMIO_TX_DATA), width: WIDTH_BYTE, enable: 1'b1, value: 32'h99};
    #1;
    check("reset_complete", {31'd0, mmio_complete}, 0);
    check("reset_avail", {31'd0, tx_data_available}, 0);
    mmio_control.enable = 1'b0;
    @(negedge clock);
    reset_n = 1'b1;
    #1;
    check("reset_leds", {30'd0, leds}, 0);
    peek(reg_addr(MMIO_STATUS), rd);
    check("reset_status", rd, 32'h100);

    // Byte burst with the transmitter always ready
    for (int i = 0; i < 3; i++) begin
      access(reg_addr(MMIO_TX_DATA), WIDTH_BYTE, 32'h41 + i, 1'b1, 1, ok, rd);
      check($sformatf("burst_complete_%0d", i), {31'd0, ok}, 1);
    end
    drain("burst");

    // Fill to full, stall the ninth store, release with one ready cycle
    for (int i = 0; i < 8; i++) begin
      access(reg_addr(MMIO_TX_DATA), WIDTH_BYTE, 32'h60 + i, 1'b0, 1, ok, rd);
      check($sformatf("fill_complete_%0d", i), {31'd0, ok}, 1);
    end
    peek(reg_addr(MMIO_STATUS), rd);
    check("full_status", rd, 32'h208);
    @(negedge clock);
    tx_ready     = 1'b0;
    mmio_control = '{addr: reg_addr(MMIO_TX_DATA), width: WIDTH_BYTE, enable: 1'b1, value: 32'h68};
    #1;
    check("full_stall", {31'd0, mmio_complete}, 0);
    @(negedge clock);
    tx_ready = 1'b1;
    #1;
    check("full_stall_ready", {31'd0, mmio_complete}, 0);
    @(negedge clock);
    tx_ready = 1'b0;
    #1;
    check("full_release", {31'd0, mmio_complete}, 1);
    if (mmio_complete) exp_q.push_back(8'h68);
    @(posedge clock);
    #1;
    mmio_control.enable = 1'b0;
    peek(reg_addr(MMIO_STATUS), rd);
    check("refull_status", rd, 32'h208);
    drain("full");

    // Simultaneous push and pop at count 3, then 16 more bytes across the pointer wrap
    for (int i = 0; i < 3; i++) begin
      access(reg_addr(MMIO_TX_DATA), WIDTH_BYTE, 32'h80 + i, 1'b0, 1, ok, rd);
    end
    peek(reg_addr(MMIO_STATUS), rd);
    check("count3_status", rd, 32'h003);
    access(reg_addr(MMIO_TX_DATA), WIDTH_BYTE, 32'h83, 1'b1, 1, ok, rd);
    tx_ready = 1'b0;
    check("pushpop_complete", {31'd0, ok}, 1);
    peek(reg_addr(MMIO_STATUS), rd);
    check("pushpop_status", rd, 32'h003);
    for (int i = 0; i < 16; i++) begin
      rdy = (i % 4 == 0) ? 1'($urandom_range(0, 1)) : 1'b1;
      access(reg_addr(MMIO_TX_DATA), WIDTH_BYTE, 32'h84 + i, rdy, 4, ok, rd);
      check($sformatf("wrap_complete_%0d", i), {31'd0, ok}, 1);
    end
    drain("wrap");

    // LED registers, error flag and window decode
    for (int i = 0; i < 15; i++) begin
      access(vecs[i].addr, vecs[i].width, vecs[i].value, 1'b0, 1, ok, rd);
      check($sformatf("v%0d_complete", i), {31'd0, ok}, {31'd0, vecs[i].exp_complete});
      @(negedge clock);
      #1;
      check($sformatf("v%0d_leds", i), {30'd0, leds}, {30'd0, vecs[i].exp_leds});
      peek(reg_addr(MMIO_STATUS), rd);
      check($sformatf("v%0d_status", i), rd, vecs[i].exp_status);
    end
    peek(BASE + 32'h14, rd);
    check("unmapped_read", rd, 0);
    peek(BASE + 32'h50, rd);
    check("outside_read", rd, 0);

    // Reset while a store is stalled on a full FIFO
    for (int i = 0; i < 8; i++) begin
      access(reg_addr(MMIO_TX_DATA), WIDTH_BYTE, 32'hA0 + i, 1'b0, 1, ok, rd);
    end
    @(negedge clock);
    mmio_control = '{addr: reg_addr(MMIO_TX_DATA), width: WIDTH_BYTE, enable: 1'b1, value: 32'hAA};
    reset_n = 1'b0;
    #1;
    check("midreset_complete", {31'd0, mmio_complete}, 0);
    check("midreset_avail", {31'd0, tx_data_available}, 0);
    @(negedge clock);
    #1;
    check("midreset_complete2", {31'd0, mmio_complete}, 0);
    mmio_control.enable = 1'b0;
    reset_n = 1'b1;
    exp_q.delete();
    #1;
    check("postreset_avail", {31'd0, tx_data_available}, 0);
    check("postreset_leds", {30'd0, leds}, 0);
    peek(reg_addr(MMIO_STATUS), rd);
    check("postreset_status", rd, 32'h100);

    repeat (2) @(negedge clock);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
